// File: rtl/p2p_pkg.sv
// Shared definitions for the two-node 4-bit point-to-point link.
// Provides role constants, the data width, the LFSR tap mask and helpers.
// Combinational helpers only; no ports, no state.
package p2p_pkg;

  localparam int ROLE_INITIATOR = 0;
  localparam int ROLE_RESPONDER = 1;

  localparam int DATA_W = 4;

  typedef logic [DATA_W-1:0] word_t;

  // Taps for x^4 + x^3 + 1: feedback is bit3 ^ bit2, shifted in at bit0.
  localparam word_t LFSR_TAP      = 4'b1100;
  localparam word_t SEED_FALLBACK = 4'b0001;

  // One LFSR step: shift left, feed the tap parity into the LSB.
  function automatic word_t lfsr_next(input word_t s);
    return {s[DATA_W-2:0], ^(s & LFSR_TAP)};
  endfunction

  // An all-zero seed would lock the LFSR up, so it is replaced by 0001.
  function automatic word_t seed_fix(input word_t s);
    return (s == '0) ? SEED_FALLBACK : s;
  endfunction

endpackage

// File: rtl/p2p_if.sv
// One direction of the point-to-point link: a single 4-bit data word.
// Ports: data (driven by the master modport, read by the slave modport).
// No handshake; the word is sampled on every rising clock edge.
interface p2p_if;
  import p2p_pkg::*;

  word_t data;

  modport master (output data);
  modport slave  (input  data);

endinterface

// File: rtl/p2p_lfsr4.sv
// Seeded 4-bit maximal-length LFSR (x^4+x^3+1, period 15) with step enable.
// Ports: clk, rst_n (async active-low), en (advance one step), q (state).
// q is registered; reset loads the seed (0001 if the seed is 0).
module p2p_lfsr4
  import p2p_pkg::*;
#(
  parameter word_t SEED = 4'b0001
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  output word_t q
);

  localparam word_t START = seed_fix(SEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= START;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/p2p_node.sv
// One endpoint of a two-node 4-bit link: initiator (ROLE=0) sends an LFSR
// stream and checks the echo; responder (ROLE=1) returns rx_data + 1.
// Ports: clk, rst_n (async active-low), rx_data (from peer), tx_data (to peer,
// registered, one edge of latency). Defining P2P_STATUS_EN adds match_cnt,
// err_cnt (saturating) and link_ok outputs; responders drive them to 0.
module p2p_node
  import p2p_pkg::*;
#(
  parameter int    ROLE  = ROLE_INITIATOR,
  parameter word_t SEED  = 4'b0001,
  parameter int    CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  word_t            rx_data,
  output word_t            tx_data
`ifdef P2P_STATUS_EN
  ,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             link_ok
`endif
);

  word_t tx_q;

  assign tx_data = tx_q;

  generate
    if (ROLE == ROLE_INITIATOR) begin : g_init

      p2p_lfsr4 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (tx_q)
      );

`ifdef P2P_STATUS_EN
      localparam logic [CNT_W-1:0] CNT_MAX = '1;

      // tx_d1 holds the word sent two edges before the current sample, which
      // is what the responder's echo (plus one) must correspond to.
      word_t      tx_d1;
      word_t      exp_rx;
      logic       warm;
      logic [1:0] run;
      logic       hit;

      assign exp_rx = tx_d1 + 4'd1;

      // Written as an if so that an X/Z on rx_data falls through to a miss.
      always_comb begin
        hit = 1'b0;
        if (rx_data == exp_rx) begin
          hit = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tx_d1     <= '0;
          warm      <= 1'b0;
          run       <= 2'd0;
          link_ok   <= 1'b0;
          match_cnt <= '0;
          err_cnt   <= '0;
        end else begin
          tx_d1 <= tx_q;
          warm  <= 1'b1;
          // The first edge after reset has no valid echo in flight yet.
          if (warm) begin
            if (hit) begin
              if (match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + 1'b1;
              end
              // run counts preceding consecutive hits (saturates at 3), so a
              // hit with run==3 is the fourth in a row.
              if (run == 2'd3) begin
                link_ok <= 1'b1;
              end else begin
                run <= run + 2'd1;
              end
            end else begin
              if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
              end
              run     <= 2'd0;
              link_ok <= 1'b0;
            end
          end
        end
      end
`else
      // Without status outputs the initiator never looks at the echo.
      logic unused_rx;
      assign unused_rx = ^rx_data;
`endif

    end else begin : g_resp

      // Echo plus one; X/Z on rx_data propagates to tx_data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tx_q <= '0;
        end else begin
          tx_q <= rx_data + 4'd1;
        end
      end

`ifdef P2P_STATUS_EN
      assign match_cnt = '0;
      assign err_cnt   = '0;
      assign link_ok   = 1'b0;
`endif

    end
  endgenerate

endmodule

// File: tb/tb_p2p_node.sv
// Self-checking bench for p2p_node: standalone initiator/responder, a linked
// pair with echo-fault injection, a SEED=0 initiator, mid-run resets and a
// randomized phase checked against a behavioural model of the link.
`timescale 1ns/1ps
module tb_p2p_node;
    import p2p_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n;
    word_t ini_rx, res_rx;
    logic  inj;
    word_t ini_tx, res_tx, z_tx;
    word_t pa_rx;
    logic  test_done = 1'b0;

    p2p_if link_ab ();
    p2p_if link_ba ();

    assign pa_rx = inj ? 4'h0 : link_ba.data;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef P2P_STATUS_EN
    logic [7:0] ini_m, ini_e, res_m, res_e, pa_m, pa_e, pb_m, pb_e, z_m, z_e;
    logic       ini_ok, res_ok, pa_ok, pb_ok, z_ok;
`endif

    p2p_node #(.ROLE(ROLE_INITIATOR), .SEED(4'b0001), .CNT_W(8)) u_ini (
        .clk(clk), .rst_n(rst_n), .rx_data(ini_rx), .tx_data(ini_tx)
`ifdef P2P_STATUS_EN
        , .match_cnt(ini_m), .err_cnt(ini_e), .link_ok(ini_ok)
`endif
    );

    p2p_node #(.ROLE(ROLE_RESPONDER), .SEED(4'b0001), .CNT_W(8)) u_res (
        .clk(clk), .rst_n(rst_n), .rx_data(res_rx), .tx_data(res_tx)
`ifdef P2P_STATUS_EN
        , .match_cnt(res_m), .err_cnt(res_e), .link_ok(res_ok)
`endif
    );

    p2p_node #(.ROLE(ROLE_INITIATOR), .SEED(4'b0001), .CNT_W(8)) u_pa (
        .clk(clk), .rst_n(rst_n), .rx_data(pa_rx), .tx_data(link_ab.data)
`ifdef P2P_STATUS_EN
        , .match_cnt(pa_m), .err_cnt(pa_e), .link_ok(pa_ok)
`endif
    );

    p2p_node #(.ROLE(ROLE_RESPONDER), .SEED(4'b0001), .CNT_W(8)) u_pb (
        .clk(clk), .rst_n(rst_n), .rx_data(link_ab.data), .tx_data(link_ba.data)
`ifdef P2P_STATUS_EN
        , .match_cnt(pb_m), .err_cnt(pb_e), .link_ok(pb_ok)
`endif
    );

    p2p_node #(.ROLE(ROLE_INITIATOR), .SEED(4'b0000), .CNT_W(8)) u_z (
        .clk(clk), .rst_n(rst_n), .rx_data(ini_rx), .tx_data(z_tx)
`ifdef P2P_STATUS_EN
        , .match_cnt(z_m), .err_cnt(z_e), .link_ok(z_ok)
`endif
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int m;
        int e;
        int run;
    } st_t;

    word_t a_after[$];   // initiator transmit word after edge k (k=0: reset)
    word_t pb_after[$];  // linked responder transmit word after edge k
    word_t res_exp;
    int    edge_n;
    st_t   st_ini, st_pa;

    function automatic word_t lfsr_ref(input word_t s);
        int v;
        v = ((int'(s) * 2) % 16) + (((int'(s) / 8) + (int'(s) / 4)) % 2);
        return word_t'(v);
    endfunction

    function automatic st_t st_upd(input st_t s, input word_t rx, input word_t exp);
        st_t r;
        r = s;
        if (rx === exp) begin
            if (r.m < 255) r.m++;
            r.run++;
        end else begin
            if (r.e < 255) r.e++;
            r.run = 0;
        end
        return r;
    endfunction

    task automatic model_reset();
        a_after.delete();
        pb_after.delete();
        a_after.push_back(4'b0001);
        pb_after.push_back(4'b0000);
        res_exp = 4'b0000;
        edge_n  = 0;
        st_ini  = '{0, 0, 0};
        st_pa   = '{0, 0, 0};
    endtask

    task automatic check_all();
        chk("ini_tx", ini_tx, a_after[edge_n]);
        chk("z_tx", z_tx, a_after[edge_n]);
        chk("pa_tx", link_ab.data, a_after[edge_n]);
        chk("pb_tx", link_ba.data, pb_after[edge_n]);
        chk("res_tx", res_tx, res_exp);
`ifdef P2P_STATUS_EN
        chk("ini_match", ini_m, 8'(st_ini.m));
        chk("ini_err", ini_e, 8'(st_ini.e));
        chk("ini_link", ini_ok, (st_ini.run >= 4));
        chk("z_match", z_m, 8'(st_ini.m));
        chk("z_err", z_e, 8'(st_ini.e));
        chk("pa_match", pa_m, 8'(st_pa.m));
        chk("pa_err", pa_e, 8'(st_pa.e));
        chk("pa_link", pa_ok, (st_pa.run >= 4));
        chk("res_status", {res_m, res_e, res_ok, pb_m, pb_e, pb_ok}, 34'd0);
`endif
    endtask

    // One rising edge: capture what the DUTs sample, step the model, check.
    task automatic tick();
        word_t ini_s, res_s, pa_s, ex, nx;
        ini_s = ini_rx;
        res_s = res_rx;
        pa_s  = inj ? 4'h0 : pb_after[edge_n];
        @(posedge clk);
        #1;
        edge_n++;
        if (edge_n >= 2) begin
            ex     = a_after[edge_n-2] + 4'd1;
            st_ini = st_upd(st_ini, ini_s, ex);
            st_pa  = st_upd(st_pa, pa_s, ex);
        end
        nx = lfsr_ref(a_after[edge_n-1]);
        a_after.push_back(nx);
        nx = a_after[edge_n-1] + 4'd1;
        pb_after.push_back(nx);
        res_exp = res_s + 4'd1;
        check_all();
    endtask

    // Called at posedge+1: reset asserted mid-cycle, released before next edge.
    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_ini_tx", ini_tx, 4'b0001);
        chk("mid_rst_res_tx", res_tx, 4'b0000);
        check_all();
        #3 rst_n = 1'b1;
    endtask

    word_t lfsr_dir [6];

    initial begin
        #200000;
        if (!test_done) begin
            n_fail++;
            $error("FAIL timeout: test did not complete within the wait limit");
            $finish;
        end
    end

    initial begin
        lfsr_dir = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101};
        rst_n  = 1'b0;
        ini_rx = 4'h0;
        res_rx = 4'h0;
        inj    = 1'b0;
        model_reset();
        #11;
        chk("rst_ini_tx", ini_tx, 4'b0001);
        chk("rst_z_seed0", z_tx, 4'b0001);
        chk("rst_res_tx", res_tx, 4'b0000);
        check_all();
        #1 rst_n = 1'b1;

        // Phase 1: idle standalone rx, error-free linked pair, full LFSR period.
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k <= 6) chk("lfsr_seq", ini_tx, lfsr_dir[k-1]);
            if (k == 1) chk("pair_echo_e1", link_ba.data, 4'b0010);
            if (k == 15) chk("lfsr_wrap", ini_tx, 4'b0001);
`ifdef P2P_STATUS_EN
            if (k == 4) chk("link_pre", pa_ok, 1'b0);
            if (k == 5) chk("link_e5", pa_ok, 1'b1);
            if (k == 10) chk("pair_match10", pa_m, 8'd9);
            if (k == 10) chk("pair_err10", pa_e, 8'd0);
`endif
        end

        // Phase 2: mid-run reset, then fault at edge 6 and responder wrap.
        pulse_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) res_rx = 4'b0101;
            if (k == 3) res_rx = 4'b1111;
            if (k == 6) inj = 1'b1;
            tick();
            inj = 1'b0;
`ifdef P2P_STATUS_EN
            if (k == 1) chk("warmup_nocmp", 8'(pa_m + pa_e), 8'd0);
            if (k == 6) chk("fault_err", pa_e, 8'd1);
            if (k >= 6 && k <= 9) chk("fault_link_low", pa_ok, 1'b0);
            if (k == 10) chk("fault_link_back", pa_ok, 1'b1);
            if (k == 10) chk("fault_match10", pa_m, 8'd8);
`endif
            if (k == 2) chk("resp_echo", res_tx, 4'b0110);
            if (k == 3) chk("resp_wrap", res_tx, 4'b0000);
        end

        // Phase 3: randomized traffic, faults, X on rx, occasional resets.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            if (edge_n >= 1 && $urandom_range(0, 1) == 0)
                ini_rx = a_after[edge_n-1] + 4'd1;
            else if ($urandom_range(0, 15) == 0)
                ini_rx = 4'bxxxx;
            else
                ini_rx = word_t'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)
                res_rx = 4'bxxxx;
            else
                res_rx = word_t'($urandom_range(0, 15));
            inj = ($urandom_range(0, 4) == 0);
            tick();
        end
        inj = 1'b0;

        test_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/p2p_node.md
Name: p2p_node

Overview:
- One endpoint of a two-node point-to-point 4-bit interconnect; the peer's tx_data is wired to this node's rx_data and vice versa.
- Parameter ROLE selects the node type:
  - Initiator (node A): transmits a 4-bit LFSR stream.
  - Responder (node B): echoes each received word plus one.
- The initiator checks the round-trip echo and keeps link-health counters.

Parameters:
- ROLE, 0, 0 = initiator (A), 1 = responder (B).
- SEED, 4'b0001, initiator LFSR reset value; 0 is treated as 4'b0001.
- CNT_W, 8, width of the status counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  4  word from the peer's tx_data.
- tx_data  out  4  registered word sent to the peer.

Behaviour:
- All state is registered, with asynchronous clear on rst_n low; sampling happens on the rising clk edge after rst_n deasserts.
- Initiator transmit:
  - Reset: tx_q = SEED (or 4'b0001 if SEED is 0).
  - Each edge: tx_q <= {tx_q[2:0], tx_q[3]^tx_q[2]} (x^4+x^3+1, period 15).
  - tx_d1 <= tx_q; tx_d1 resets to 0.
  - tx_data = tx_q.
- Responder transmit:
  - Reset: tx_q = 0.
  - Each edge: tx_q <= rx_data + 1, modulo 16 (1111 wraps to 0000).
  - tx_data = tx_q, so there is one edge of latency.
- Round trip: the value the initiator samples at edge k+1 equals its own transmit after edge k-1, plus one.
- Initiator check:
  - At each edge, compare rx_data against tx_d1 + 1 (mod 16).
  - The first edge after reset is warm-up and no compare occurs; a 1-bit warm-up flag sets on that edge.
- Responder: no check logic; all status state is tied to 0.
- X or Z on rx_data counts as a mismatch in the initiator; the responder propagates it.
- Reset mid-operation clears all state immediately, including the warm-up flag.

Optional Feature:
- P2P_STATUS_EN defined adds three output ports after tx_data:
  - match_cnt [CNT_W-1:0]: saturating count of compares that matched.
  - err_cnt [CNT_W-1:0]: saturating count of mismatches.
  - link_ok [1]: 1 when the last 4 consecutive compares matched; cleared by a mismatch or by reset.
- Both counters reset to 0 and saturate at all-ones.
- In a responder, all three outputs are constant 0.
- P2P_STATUS_EN undefined: the port list is exactly clk, rst_n, rx_data, tx_data. Compare logic may be removed, and the tx_data behaviour is identical.

Decomposition:
- Shared package p2p_pkg:
  - ROLE_INITIATOR = 0, ROLE_RESPONDER = 1.
  - DATA_W = 4.
  - LFSR_TAP constant.
  - Function lfsr_next(4-bit) -> 4-bit.
- Sub-module p2p_lfsr4 (seeded LFSR with enable), instantiated only when ROLE = 0 via generate.
- Status counters stay inline in p2p_node.

Test Plan:
1. Initiator LFSR sequence: initiator, SEED 0001, reset released, rx idle → tx_data = 0001, then 0010, 0100, 1001, 0011, 0110, 1101 on successive edges; the word after the 15th edge returns to 0001.
2. Responder echo and wrap: responder, rx_data = 0101 at an edge → tx_data = 0110 after that edge; rx_data = 1111 → 0000 (wrap); reset → tx_data = 0000.
3. Linked pair, error-free: initiator and responder cross-connected, 10 edges after reset → responder shows 0001+1 = 0010 after edge 1. With status enabled: match_cnt = 9, err_cnt = 0, link_ok = 1 from edge 5.
4. Fault injection: linked pair, rx_data forced to 0000 for one edge at edge 6 → err_cnt = 1 and link_ok = 0 for 4 edges, then link_ok returns to 1; match_cnt keeps counting other edges.
5. Mid-run reset and seed: rst_n pulsed low mid-cycle → tx_data returns to SEED immediately (initiator) or 0000 (responder), counters clear, and the first edge after release is not compared. SEED = 0 → initiator starts at 0001.
